// File: rtl/circuito_exp5_jogo_if.sv
// rtl/circuito_exp5_jogo_if.sv - player-facing signal bundle of the memory game
interface circuito_exp5_jogo_if;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic [3:0] leds;

  // board / testbench side: drives the player inputs, observes the result flags
  modport master (
    output iniciar,
    output chaves,
    input  acertou,
    input  errou,
    input  pronto,
    input  leds
  );

  // game side
  modport slave (
    input  iniciar,
    input  chaves,
    output acertou,
    output errou,
    output pronto,
    output leds
  );
endinterface

// File: rtl/circuito_exp5_jogo.sv
// rtl/circuito_exp5_jogo.sv - memory game top: FSM, round counter, jogada reg, ROM, compare, debug hex (LEDS_MEMORIA_EN = training leds)
module circuito_exp5_jogo (
  input  logic                       clock,
  input  logic                       reset,
  circuito_exp5_jogo_if.slave        jogo,
  output logic                       db_igual,
  output logic [6:0]                 db_contagem,
  output logic [6:0]                 db_memoria,
  output logic [6:0]                 db_estado,
  output logic [6:0]                 db_jogadafeita,
  output logic                       db_clock,
  output logic                       db_iniciar,
  output logic                       db_tem_jogada
);

  // State codes double as the value shown on the db_estado display.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } estado_t;

  localparam logic [3:0] ULTIMA_RODADA = 4'hF;

  estado_t    estado_q, estado_d;
  logic [3:0] contador_q, contador_d;
  logic [3:0] jogada_q, jogada_d;
  logic       prev_q, prev_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic       pronto_q, pronto_d;

  logic [3:0] memoria;
  logic       igual;
  logic       tem_jogada;

  // Fixed 16-entry one-hot sequence the player has to reproduce.
  function automatic logic [3:0] rom_sequencia(input logic [3:0] addr);
    logic [3:0] dado;
    case (addr)
      4'h0:    dado = 4'h1;
      4'h1:    dado = 4'h2;
      4'h2:    dado = 4'h4;
      4'h3:    dado = 4'h8;
      4'h4:    dado = 4'h4;
      4'h5:    dado = 4'h2;
      4'h6:    dado = 4'h1;
      4'h7:    dado = 4'h1;
      4'h8:    dado = 4'h2;
      4'h9:    dado = 4'h2;
      4'hA:    dado = 4'h4;
      4'hB:    dado = 4'h4;
      4'hC:    dado = 4'h8;
      4'hD:    dado = 4'h8;
      4'hE:    dado = 4'h1;
      default: dado = 4'h4;
    endcase
    return dado;
  endfunction

  // Hex to 7-segment, bit order gfedcba, segments lit when low.
  function automatic logic [6:0] hex7seg(input logic [3:0] valor);
    logic [6:0] seg;
    case (valor)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign memoria    = rom_sequencia(contador_q);
  assign igual      = (jogada_q == memoria);
  // A press is the first cycle any switch is up after all were down.
  assign tem_jogada = (|jogo.chaves) & ~prev_q;

  // Next-state, datapath and Moore flag computation.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    jogada_d   = jogada_q;
    prev_d     = |jogo.chaves;

    case (estado_q)
      INICIAL: begin
        if (jogo.iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        contador_d = 4'h0;
        jogada_d   = 4'h0;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        if (tem_jogada) estado_d = REGISTRA;
      end
      REGISTRA: begin
        jogada_d = jogo.chaves;
        estado_d = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)                          estado_d = FIM_ERROU;
        else if (contador_q == ULTIMA_RODADA) estado_d = FIM_ACERTOU;
        else                                 estado_d = PROXIMO;
      end
      PROXIMO: begin
        contador_d = contador_q + 4'h1;
        estado_d   = ESPERA;
      end
      FIM_ACERTOU: begin
        if (jogo.iniciar) estado_d = PREPARACAO;
      end
      FIM_ERROU: begin
        if (jogo.iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase

    // Flags are registered from the next state so they track the state exactly.
    acertou_d = (estado_d == FIM_ACERTOU);
    errou_d   = (estado_d == FIM_ERROU);
    pronto_d  = (estado_d == FIM_ACERTOU) || (estado_d == FIM_ERROU);
  end

  // All game state, with an immediate abort to inicial on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      contador_q <= 4'h0;
      jogada_q   <= 4'h0;
      prev_q     <= 1'b0;
      acertou_q  <= 1'b0;
      errou_q    <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      jogada_q   <= jogada_d;
      prev_q     <= prev_d;
      acertou_q  <= acertou_d;
      errou_q    <= errou_d;
      pronto_q   <= pronto_d;
    end
  end

  assign jogo.acertou = acertou_q;
  assign jogo.errou   = errou_q;
  assign jogo.pronto  = pronto_q;

`ifdef LEDS_MEMORIA_EN
  assign jogo.leds = memoria;
`else
  assign jogo.leds = jogo.chaves;
`endif

  assign db_igual       = igual;
  assign db_contagem    = hex7seg(contador_q);
  assign db_memoria     = hex7seg(memoria);
  assign db_estado      = hex7seg(estado_q);
  assign db_jogadafeita = hex7seg(jogada_q);
  assign db_clock       = clock;
  assign db_iniciar     = jogo.iniciar;
  assign db_tem_jogada  = tem_jogada;

endmodule

// File: tb/tb_circuito_exp5_jogo.sv
// tb/tb_circuito_exp5_jogo.sv - directed self-checking bench for circuito_exp5_jogo
module tb_circuito_exp5_jogo;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  logic       clock;
  logic       reset;
  logic       db_igual;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
  logic       db_clock, db_iniciar, db_tem_jogada;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  circuito_exp5_jogo_if jogo_if ();

  circuito_exp5_jogo dut (
    .clock          (clock),
    .reset          (reset),
    .jogo           (jogo_if.slave),
    .db_igual       (db_igual),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_clock       (db_clock),
    .db_iniciar     (db_iniciar),
    .db_tem_jogada  (db_tem_jogada)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (db_tem_jogada) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulso_iniciar(input int n);
    jogo_if.iniciar = 1'b1;
    ciclos(n);
    jogo_if.iniciar = 1'b0;
    ciclos(2);
  endtask

  // Switch held 10 cycles, then released for 10 cycles.
  task automatic jogada(input logic [3:0] valor);
    jogo_if.chaves = valor;
    ciclos(10);
    jogo_if.chaves = 4'h0;
    ciclos(10);
  endtask

  initial begin
    reset           = 1'b1;
    jogo_if.iniciar = 1'b0;
    jogo_if.chaves  = 4'h0;
    #2 reset = 1'b0;
    ciclos(1);
    reset = 1'b1;
    ciclos(1);

    check("reset_estado",   db_estado, SEG_0);
    check("reset_acertou",  jogo_if.acertou, 0);
    check("reset_errou",    jogo_if.errou, 0);
    check("reset_pronto",   jogo_if.pronto, 0);
    check("reset_contagem", db_contagem, SEG_0);
    check("reset_jogada",   db_jogadafeita, SEG_0);

    pulso_iniciar(5);
    check("start_estado",   db_estado, SEG_2);
    check("start_contagem", db_contagem, SEG_0);
    check("start_memoria",  db_memoria, SEG_1);
    check("start_igual",    db_igual, 0);
`ifdef LEDS_MEMORIA_EN
    check("start_leds",     jogo_if.leds, 4'h1);
`else
    check("start_leds",     jogo_if.leds, 4'h0);
`endif

    // Full correct game.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        jogo_if.chaves = seq[i];
        ciclos(1);
`ifdef LEDS_MEMORIA_EN
        check("leds_press", jogo_if.leds, 4'h8);
`else
        check("leds_press", jogo_if.leds, seq[i]);
`endif
        ciclos(9);
        jogo_if.chaves = 4'h0;
        ciclos(10);
      end else begin
        jogada(seq[i]);
      end
      if (i < 15) check($sformatf("contagem_%0d", i), db_contagem, seg_tab[i + 1]);
    end
    check("win_pulses",   pulses, 16);
    check("win_acertou",  jogo_if.acertou, 1);
    check("win_pronto",   jogo_if.pronto, 1);
    check("win_errou",    jogo_if.errou, 0);
    check("win_estado",   db_estado, SEG_A);
    check("win_contagem", db_contagem, SEG_F);
    check("win_jogada",   db_jogadafeita, SEG_4);
    check("win_igual",    db_igual, 1);
    ciclos(20);
    check("win_hold",     jogo_if.acertou, 1);

    // Restart from win, then lose at the fourth round.
    pulso_iniciar(1);
    check("rst1_acertou",  jogo_if.acertou, 0);
    check("rst1_pronto",   jogo_if.pronto, 0);
    check("rst1_estado",   db_estado, SEG_2);
    check("rst1_contagem", db_contagem, SEG_0);
    jogada(4'h1);
    jogada(4'h2);
    jogada(4'h4);
    jogada(4'h1);
    check("lose_errou",    jogo_if.errou, 1);
    check("lose_pronto",   jogo_if.pronto, 1);
    check("lose_acertou",  jogo_if.acertou, 0);
    check("lose_contagem", db_contagem, SEG_3);
    check("lose_estado",   db_estado, SEG_E);

    // Restart from lose; held switch gives a single pulse and one round.
    pulso_iniciar(3);
    check("rst2_errou",    jogo_if.errou, 0);
    check("rst2_pronto",   jogo_if.pronto, 0);
    check("rst2_estado",   db_estado, SEG_2);
    check("rst2_contagem", db_contagem, SEG_0);
    pulses = 0;
    jogada(4'h1);
    check("hold_pulses",   pulses, 1);
    check("hold_contagem", db_contagem, SEG_1);
    check("hold_estado",   db_estado, SEG_2);

    // iniciar in espera is ignored.
    pulso_iniciar(2);
    check("ign_contagem",  db_contagem, SEG_1);
    check("ign_estado",    db_estado, SEG_2);

    // Asynchronous reset mid-game, observed before the next clock edge.
    jogada(4'h2);
    check("pre_rst_contagem", db_contagem, SEG_2);
    #2 reset = 1'b0;
    #1;
    check("async_estado",   db_estado, SEG_0);
    check("async_contagem", db_contagem, SEG_0);
    ciclos(2);
    reset = 1'b1;
    ciclos(2);
    check("post_rst_estado", db_estado, SEG_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
